// File: rtl/meas_capture_engine.sv
// Multi-channel ADC capture into dual-port storage with sequential readout.
// Define MEAS_AVG_EN to replace decimation with per-channel boxcar averaging.
module meas_capture_engine #(
    parameter int ADC_WIDTH = 12,
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 4096,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_valid,
    input  logic [NUM_CH*ADC_WIDTH-1:0] adc_data,
    input  logic                        start,
    input  logic                        abort,
    input  logic [CNT_W-1:0]            num_points,
    input  logic [7:0]                  decim,
    input  logic                        rd_req,
    output logic [NUM_CH*ADC_WIDTH-1:0] rd_data,
    output logic                        rd_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        underrun,
    output logic [CNT_W-1:0]            points_left
);

    localparam int DW = NUM_CH * ADC_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_READY,
        S_READOUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DW-1:0]    r_mem [DEPTH];
    logic [CNT_W-1:0] r_n_eff;
    logic [7:0]       r_decim;
    logic [CNT_W-1:0] r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [7:0]       r_dcnt;
    logic [DW-1:0]    r_rd_data;
    logic             r_rd_valid;
    logic             r_underrun;
    logic [CNT_W-1:0] r_points_left;

    logic             w_avail;
    logic             w_start_ok;
    logic             w_strobe;
    logic             w_tick;
    logic             w_store;
    logic             w_last;
    logic             w_rd_acc;
    logic             w_rd_last;
    logic [CNT_W-1:0] w_n_eff;
    logic [DW-1:0]    w_wdata;

    assign w_avail    = (r_state == S_READY || r_state == S_READOUT)
                        && (r_points_left != '0);
    assign w_start_ok = start && !abort
                        && (r_state == S_IDLE || r_state == S_READY);
    assign w_strobe   = (r_state == S_CAPTURE) && sample_valid && !abort;
    assign w_store    = w_strobe && w_tick;
    assign w_last     = w_store && ((r_wr_ptr + CNT_W'(1)) == r_n_eff);
    // A restart from READY takes priority over a read in the same cycle.
    assign w_rd_acc   = rd_req && w_avail && !abort && !w_start_ok;
    assign w_rd_last  = w_rd_acc && (r_points_left == CNT_W'(1));
    assign w_n_eff    = (num_points == '0 || num_points > DEPTH_C)
                        ? DEPTH_C : num_points;

`ifdef MEAS_AVG_EN
    localparam int ACC_W = ADC_WIDTH + 7;

    assign w_tick = (r_dcnt == ((8'd1 << r_decim[2:0]) - 8'd1));

    for (genvar k = 0; k < NUM_CH; k++) begin : g_avg
        logic [ACC_W-1:0] r_acc;
        logic [ACC_W-1:0] w_sum;
        logic [ACC_W-1:0] w_avg;

        assign w_sum = r_acc + ACC_W'(adc_data[k*ADC_WIDTH +: ADC_WIDTH]);
        assign w_avg = w_sum >> r_decim[2:0];
        assign w_wdata[k*ADC_WIDTH +: ADC_WIDTH] = w_avg[ADC_WIDTH-1:0];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_acc <= '0;
            end else if (abort || w_start_ok || w_store) begin
                r_acc <= '0;
            end else if (w_strobe) begin
                r_acc <= w_sum;
            end
        end
    end
`else
    assign w_tick  = (r_dcnt == r_decim);
    assign w_wdata = adc_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) w_next = S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (w_last) w_next = S_READY;
                end
                S_READY: begin
                    if (start)          w_next = S_CAPTURE;
                    else if (w_rd_last) w_next = S_IDLE;
                    else if (w_rd_acc)  w_next = S_READOUT;
                end
                S_READOUT: begin
                    if (w_rd_last) w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n_eff       <= '0;
            r_decim       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_dcnt        <= '0;
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
            r_points_left <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            if (abort) begin
                r_dcnt        <= '0;
                r_points_left <= '0;
            end else if (w_start_ok) begin
                r_n_eff       <= w_n_eff;
                r_decim       <= decim;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_dcnt        <= '0;
                r_points_left <= '0;
            end else begin
                if (w_store) begin
                    r_wr_ptr <= r_wr_ptr + CNT_W'(1);
                    r_dcnt   <= '0;
                end else if (w_strobe) begin
                    r_dcnt <= r_dcnt + 8'd1;
                end
                if (w_last) begin
                    r_points_left <= r_n_eff;
                    r_rd_ptr      <= '0;
                end
                if (w_rd_acc) begin
                    r_rd_data     <= r_mem[r_rd_ptr];
                    r_rd_valid    <= 1'b1;
                    r_rd_ptr      <= r_rd_ptr + AW'(1);
                    r_points_left <= r_points_left - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else if (w_start_ok) begin
            r_underrun <= 1'b0;
        end else if (rd_req && !w_avail) begin
            r_underrun <= 1'b1;
        end
    end

    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign busy        = (r_state == S_CAPTURE);
    assign done        = (r_state == S_READY) || (r_state == S_READOUT);
    assign underrun    = r_underrun;
    assign points_left = r_points_left;

endmodule
